// File: rtl/prio_enc_seq.sv
// prio_enc_seq: registered priority encoder with fixed or round-robin priority and a valid/ready result hold.
module prio_enc_seq #(
  parameter  int N    = 8,
  parameter  int MODE = 0,
  localparam int W    = (N > 2) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] d,
  input  logic         ready,
  output logic [W-1:0] a,
  output logic         valid,
  output logic         multi
);
  logic [W-1:0] ptr, sel;
  logic take;
  int j;
  assign take = en && (|d) && (!valid || ready);
  // Round-robin scans downward from the farthest slot so the nearest set bit after ptr wins.
  always_comb begin
    sel = '0;
    j = 0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++)
        if (d[i]) sel = W'(i);
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        j = (int'(ptr) + k >= N) ? int'(ptr) + k - N : int'(ptr) + k;
        if (d[j]) sel = W'(j);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a     <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
      ptr   <= '0;
    end else if (take) begin
      a     <= sel;
      valid <= 1'b1;
      multi <= |(d & (d - N'(1)));
      if (MODE == 1) ptr <= (sel == W'(N - 1)) ? '0 : sel + 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prio_enc_seq.sv
// tb_prio_enc_seq: directed checks of fixed-priority (N=8) and round-robin (N=8, N=5) encoders.
module tb_prio_enc_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic ready = 1'b1;
  logic [7:0] d0 = '0, d1 = '0;
  logic [4:0] d2 = '0;
  logic [2:0] a0, a1, a2;
  logic v0, v1, v2, m0, m1, m2;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  prio_enc_seq #(.N(8), .MODE(0)) u_fix (.clk(clk), .rst_n(rst_n), .en(en), .d(d0), .ready(ready), .a(a0), .valid(v0), .multi(m0));
  prio_enc_seq #(.N(8), .MODE(1)) u_rr8 (.clk(clk), .rst_n(rst_n), .en(en), .d(d1), .ready(ready), .a(a1), .valid(v1), .multi(m1));
  prio_enc_seq #(.N(5), .MODE(1)) u_rr5 (.clk(clk), .rst_n(rst_n), .en(en), .d(d2), .ready(ready), .a(a2), .valid(v2), .multi(m2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({a0, v0, m0} !== 4'b0) begin bad++; $display("FAIL reset_fix got a=%0d v=%0b m=%0b exp 0/0/0", a0, v0, m0); end
    total++; if ({a1, v1, m1, a2, v2, m2} !== 10'b0) begin bad++; $display("FAIL reset_rr got a1=%0d v1=%0b a2=%0d v2=%0b exp zeros", a1, v1, a2, v2); end
    en = 1'b1;
    d0 = 8'hFF;
    tick();
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL reset_hold got v=%0b exp 0", v0); end
    d0 = 8'h00;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_onehot;
    for (int i = 0; i < 8; i++) begin
      d0 = 8'h01 << i;
      tick();
      total++; if (a0 !== 3'(i)) begin bad++; $display("FAIL onehot_a i=%0d got=%0d exp=%0d", i, a0, i); end
      total++; if (v0 !== 1'b1 || m0 !== 1'b0) begin bad++; $display("FAIL onehot_vm i=%0d got v=%0b m=%0b exp 1/0", i, v0, m0); end
    end
  endtask

  task automatic test_multi;
    d0 = 8'h2C;
    tick();
    total++; if (a0 !== 3'd5 || m0 !== 1'b1 || v0 !== 1'b1) begin bad++; $display("FAIL multi_cap got a=%0d m=%0b v=%0b exp 5/1/1", a0, m0, v0); end
    d0 = 8'h00;
    tick();
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL multi_drop got v=%0b exp 0", v0); end
    total++; if (a0 !== 3'd5 || m0 !== 1'b1) begin bad++; $display("FAIL multi_hold got a=%0d m=%0b exp 5/1", a0, m0); end
  endtask

  task automatic test_round_robin;
    d1 = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      total++; if (a1 !== 3'(i % 8) || v1 !== 1'b1) begin bad++; $display("FAIL rr8_seq i=%0d got a=%0d v=%0b exp %0d/1", i, a1, v1, i % 8); end
    end
    d1 = 8'h81;
    tick();
    total++; if (a1 !== 3'd7) begin bad++; $display("FAIL rr8_wrap1 got=%0d exp=7", a1); end
    tick();
    total++; if (a1 !== 3'd0) begin bad++; $display("FAIL rr8_wrap2 got=%0d exp=0", a1); end
    d1 = 8'h00;
    tick();
  endtask

  task automatic test_stall;
    d0 = 8'h10;
    tick();
    total++; if (a0 !== 3'd4 || v0 !== 1'b1) begin bad++; $display("FAIL stall_cap got a=%0d v=%0b exp 4/1", a0, v0); end
    ready = 1'b0;
    d0 = 8'h02;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (a0 !== 3'd4 || v0 !== 1'b1) begin bad++; $display("FAIL stall_hold c=%0d got a=%0d v=%0b exp 4/1", i, a0, v0); end
    end
    ready = 1'b1;
    tick();
    total++; if (a0 !== 3'd1 || v0 !== 1'b1 || m0 !== 1'b0) begin bad++; $display("FAIL stall_release got a=%0d v=%0b m=%0b exp 1/1/0", a0, v0, m0); end
    d0 = 8'h00;
    tick();
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL stall_drain got v=%0b exp 0", v0); end
  endtask

  task automatic test_n5_wrap;
    d2 = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      tick();
      total++; if (a2 !== 3'(i % 5) || v2 !== 1'b1 || m2 !== 1'b1) begin bad++; $display("FAIL rr5_seq i=%0d got a=%0d v=%0b m=%0b exp %0d/1/1", i, a2, v2, m2, i % 5); end
    end
    d2 = 5'h00;
    tick();
  endtask

  task automatic test_reset_mid;
    d0 = 8'h40;
    d1 = 8'h08;
    tick();
    total++; if (a0 !== 3'd6 || v0 !== 1'b1) begin bad++; $display("FAIL mid_pre got a=%0d v=%0b exp 6/1", a0, v0); end
    total++; if (a1 !== 3'd3) begin bad++; $display("FAIL mid_pre_rr got=%0d exp=3", a1); end
    d0 = 8'h00;
    d1 = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    total++; if (a0 !== 3'd0 || v0 !== 1'b0 || m0 !== 1'b0) begin bad++; $display("FAIL mid_async got a=%0d v=%0b m=%0b exp 0/0/0", a0, v0, m0); end
    #2 rst_n = 1'b1;
    tick();
    total++; if (v0 !== 1'b0 || v1 !== 1'b0) begin bad++; $display("FAIL mid_nodeliver got v0=%0b v1=%0b exp 0/0", v0, v1); end
    d1 = 8'h22;
    tick();
    total++; if (a1 !== 3'd1 || v1 !== 1'b1) begin bad++; $display("FAIL mid_ptr0 got a=%0d v=%0b exp 1/1", a1, v1); end
    d1 = 8'h00;
  endtask

  task automatic test_back_to_back;
    d0 = 8'h03;
    tick();
    d0 = 8'h80;
    total++; if (a0 !== 3'd1 || m0 !== 1'b1) begin bad++; $display("FAIL b2b_first got a=%0d m=%0b exp 1/1", a0, m0); end
    tick();
    en = 1'b0;
    total++; if (a0 !== 3'd7 || m0 !== 1'b0 || v0 !== 1'b1) begin bad++; $display("FAIL b2b_second got a=%0d m=%0b v=%0b exp 7/0/1", a0, m0, v0); end
    tick();
    total++; if (v0 !== 1'b0 || a0 !== 3'd7) begin bad++; $display("FAIL b2b_en_off got a=%0d v=%0b exp 7/0", a0, v0); end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_multi();
    test_round_robin();
    test_stall();
    test_n5_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prio_enc_seq.md
PRIO_ENC_SEQ -- requirements
Module: prio_enc_seq

Interface
REQ-001 Parameter N, default 8: number of request inputs; legal range 2..64.
REQ-002 Parameter MODE, default 0: 0 = fixed priority (highest index wins), 1 = round-robin priority.
REQ-003 Derived localparam W = max(1, ceil(log2(N))), default 3: encoded index width; not overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  sample enable; requests are ignored when low.
REQ-007 d  input  N  request vector; bit i asserts request i.
REQ-008 a  output  W  encoded index of the selected request (registered).
REQ-009 valid  output  1  a and multi hold a result not yet accepted.
REQ-010 ready  input  1  downstream accepts the result when valid and ready are both high in the same cycle.
REQ-011 multi  output  1  more than one bit of d was set when the held result was captured.

Function
REQ-012 Capture condition: take = en AND (d != 0) AND (NOT valid OR ready), evaluated each cycle.
REQ-013 On take, at the next rising edge: a <= selected index, multi <= (popcount(d) > 1), valid <= 1.
REQ-014 Latency: one cycle from the sampled d to the corresponding a/valid; back-to-back captures every cycle while ready = 1.
REQ-015 If valid AND ready AND NOT take: valid <= 0; a and multi hold their values.
REQ-016 If valid AND NOT ready: a, multi and valid hold; d is ignored (no overwrite, no loss of the held result).
REQ-017 en = 0 or d = 0: no capture; the handshake still completes per REQ-015.
REQ-018 MODE 0: selected index = highest i with d[i] = 1; for one-hot d this equals the binary index of the set bit.
REQ-019 MODE 1: internal pointer ptr (width W, range 0..N-1); selected index = first set bit searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-020 MODE 1: on take, ptr <= sel+1, wrapping to 0 when sel = N-1; ptr is unchanged in all other cycles.
REQ-021 MODE 0: ptr is absent or constant and has no effect on the outputs.
REQ-022 For N not a power of two, a never exceeds N-1, and ptr wraps at N-1, not at 2^W-1.
REQ-023 Simultaneous valid&ready and take: the new result replaces the accepted one in the same edge, with no bubble and no duplicate.
REQ-024 No combinational path from d, en or ready to a, valid or multi.

Reset
REQ-025 rst_n low asynchronously forces a = 0, valid = 0, multi = 0 and ptr = 0, regardless of clk.
REQ-026 Reset asserted mid-operation discards any held result; no result is delivered after rst_n is released until a new take occurs.
REQ-027 The first capture after reset is evaluated at the first rising edge with rst_n high.

Verification
REQ-028 N=8, MODE 0, ready=1, en=1, d stepped one-hot 0x01..0x80 -> a = 0..7 one cycle later, valid=1, multi=0 each cycle.
REQ-029 N=8, MODE 0, d=0x2C -> a=5, multi=1; then d=0x00 with ready=1 -> valid falls to 0 and a holds 5.
REQ-030 N=8, MODE 1, d=0xFF held, ready=1 -> a sequence 0,1,...,7,0; then d=0x81 from ptr=1 -> a=7, then a=0.
REQ-031 Stall: capture d=0x10 (a=4), hold ready=0 for 3 cycles while d=0x02 -> a stays 4, valid stays 1; raise ready -> next cycle a=1.
REQ-032 N=5, MODE 1, d=0x1F -> a cycles 0..4 and wraps to 0; a never equals 5, 6 or 7.
REQ-033 rst_n pulsed low between clock edges while valid=1, a=6 -> a=0, valid=0, multi=0 immediately; in MODE 1 the next grant starts the search at index 0.
